// File: rtl/rx_frame_release_ctrl_if.sv
// rx_frame_release_ctrl_if: handshake and status bundle between the receive
// path (demapper, TX FIFO, UART TX, rec_tran) and rx_frame_release_ctrl.
// The controller connects through the slave modport; the surrounding logic
// (or a testbench) drives through the master modport.
interface rx_frame_release_ctrl_if;
  logic        i_pyld_valid;
  logic        i_pyld_ready;
  logic        i_crc_err;
  logic        i_crc_err_valid;
  logic        i_arq_en;
  logic        i_arq_en_valid;
  logic        i_uart_beat;
  logic        o_rx_hold;
  logic        o_fifo_flush;
  logic        o_uart_tx_enable;
  logic        o_ack_req;
  logic        o_nack_req;
  logic [3:0]  o_retry_cnt;
  logic [2:0]  o_state;
  logic [15:0] o_frame_cnt;
  logic [15:0] o_err_cnt;
  logic [15:0] o_drop_cnt;

  modport master (
    output i_pyld_valid, i_pyld_ready, i_crc_err, i_crc_err_valid,
           i_arq_en, i_arq_en_valid, i_uart_beat,
    input  o_rx_hold, o_fifo_flush, o_uart_tx_enable, o_ack_req, o_nack_req,
           o_retry_cnt, o_state, o_frame_cnt, o_err_cnt, o_drop_cnt
  );

  modport slave (
    input  i_pyld_valid, i_pyld_ready, i_crc_err, i_crc_err_valid,
           i_arq_en, i_arq_en_valid, i_uart_beat,
    output o_rx_hold, o_fifo_flush, o_uart_tx_enable, o_ack_req, o_nack_req,
           o_retry_cnt, o_state, o_frame_cnt, o_err_cnt, o_drop_cnt
  );
endinterface

// File: rtl/rx_frame_release_ctrl.sv
// rx_frame_release_ctrl: sequences the receive datapath one frame at a time.
// Payload bytes are counted into the UART TX FIFO and held until the CRC
// verdict; a good frame is released to the UART with an ACK request, a bad
// frame (CRC error, early verdict or verdict timeout) is flushed and either
// NACKed for retransmission or dropped once the retry budget is spent.
// Optional macro RX_CTRL_STATS_EN builds the frame/error/drop counters;
// without it o_frame_cnt, o_err_cnt and o_drop_cnt are tied to 0.
module rx_frame_release_ctrl #(
  parameter int PYLD_BYTES      = 16,
  parameter int MAX_RETRY       = 3,
  parameter int VERDICT_TIMEOUT = 4096
) (
  input logic               i_clk,
  input logic               i_rst,
  rx_frame_release_ctrl_if.slave bus
);
  localparam int TO_W = $clog2(VERDICT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VERDICT = 3'd2,
    S_RELEASE = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      byte_cnt, byte_cnt_nx;
  logic [TO_W-1:0] timer, timer_nx;
  logic            flush_ph, flush_ph_nx;
  logic [3:0]      retry, retry_nx;
  logic            arq_en;
  logic            ack_q, ack_nx;
  logic            nack_q, nack_nx;
  logic            go_good, go_bad;
  logic            frame_inc, err_inc, drop_inc;
  logic            accept, last_byte, timed_out, retry_ok;

  assign accept    = bus.i_pyld_valid & bus.i_pyld_ready;
  assign last_byte = (byte_cnt == 8'(PYLD_BYTES - 1));
  assign timed_out = (timer == TO_W'(VERDICT_TIMEOUT - 1));
  assign retry_ok  = arq_en && (retry < 4'(MAX_RETRY));

  // State and control registers; arq_en follows its qualifier in every state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      timer    <= '0;
      flush_ph <= 1'b0;
      retry    <= '0;
      arq_en   <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_cnt_nx;
      timer    <= timer_nx;
      flush_ph <= flush_ph_nx;
      retry    <= retry_nx;
      ack_q    <= ack_nx;
      nack_q   <= nack_nx;
      if (bus.i_arq_en_valid) arq_en <= bus.i_arq_en;
    end
  end

  // Next-state decode; a verdict decision is resolved once after the case
  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    timer_nx    = timer;
    flush_ph_nx = 1'b0;
    retry_nx    = retry;
    ack_nx      = 1'b0;
    nack_nx     = 1'b0;
    go_good     = 1'b0;
    go_bad      = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          byte_cnt_nx = 8'd1;
          state_nx    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) byte_cnt_nx = byte_cnt + 8'd1;
        if (accept && last_byte) begin
          // A verdict on the final accept is taken directly, skipping the wait
          if (bus.i_crc_err_valid) begin
            go_good = ~bus.i_crc_err;
            go_bad  = bus.i_crc_err;
          end else begin
            state_nx = S_VERDICT;
            timer_nx = '0;
          end
        end else if (bus.i_crc_err_valid) begin
          // Verdict before the payload is complete cannot be trusted
          go_bad = 1'b1;
        end
      end
      S_VERDICT: begin
        if (bus.i_crc_err_valid) begin
          go_good = ~bus.i_crc_err;
          go_bad  = bus.i_crc_err;
        end else if (timed_out) begin
          go_bad = 1'b1;
        end else begin
          timer_nx = timer + TO_W'(1);
        end
      end
      S_RELEASE: begin
        if (bus.i_uart_beat) begin
          if (last_byte) begin
            state_nx  = S_IDLE;
            frame_inc = 1'b1;
          end else begin
            byte_cnt_nx = byte_cnt + 8'd1;
          end
        end
      end
      S_FLUSH: begin
        // Two flush cycles, then decide between retransmission and drop
        if (!flush_ph) begin
          flush_ph_nx = 1'b1;
        end else begin
          state_nx = S_IDLE;
          if (retry_ok) begin
            nack_nx  = 1'b1;
            retry_nx = retry + 4'd1;
          end else begin
            drop_inc = 1'b1;
            retry_nx = '0;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (go_good) begin
      state_nx    = S_RELEASE;
      ack_nx      = 1'b1;
      retry_nx    = '0;
      byte_cnt_nx = '0;
    end
    if (go_bad) begin
      state_nx    = S_FLUSH;
      flush_ph_nx = 1'b0;
      err_inc     = 1'b1;
    end
  end

  assign bus.o_state          = state;
  assign bus.o_rx_hold        = (state == S_VERDICT) || (state == S_RELEASE) || (state == S_FLUSH);
  assign bus.o_uart_tx_enable = (state == S_RELEASE);
  assign bus.o_fifo_flush     = (state == S_FLUSH);
  assign bus.o_ack_req        = ack_q;
  assign bus.o_nack_req       = nack_q;
  assign bus.o_retry_cnt      = retry;

`ifdef RX_CTRL_STATS_EN
  logic [15:0] frame_cnt, err_cnt, drop_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating statistics counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_inc) frame_cnt <= sat_inc(frame_cnt);
      if (err_inc)   err_cnt   <= sat_inc(err_cnt);
      if (drop_inc)  drop_cnt  <= sat_inc(drop_cnt);
    end
  end

  assign bus.o_frame_cnt = frame_cnt;
  assign bus.o_err_cnt   = err_cnt;
  assign bus.o_drop_cnt  = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats    = ^{frame_inc, err_inc, drop_inc};
  assign bus.o_frame_cnt = '0;
  assign bus.o_err_cnt   = '0;
  assign bus.o_drop_cnt  = '0;
`endif
endmodule
